elevator_sched: RTL and testbench
=================================

ELEVATOR_SCHED -- requirements
Module: elevator_sched

Interface
REQ-001 SHALL have parameter TRAVEL_CYC, default 4, giving clock cycles to travel one floor (legal range 1..255).
REQ-002 SHALL have parameter DOOR_CYC, default 8, giving clock cycles the door stays open (legal range 1..255).
REQ-003 SHALL have port clk  input  1  the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port clr  input  1  synchronous, active-high reset.
REQ-005 SHALL have port call  input  4  floor request pulses, where bit0 is the ground floor and bit3 is floor 4; multiple bits may be high at once.
REQ-006 SHALL have port cur_floor  output  2  current floor index 0..3.
REQ-007 SHALL have port dir  output  1  travel direction, where 1 = up and 0 = down.
REQ-008 SHALL have port moving  output  1  high while the car is in state MOVE.
REQ-009 SHALL have port door_open  output  1  high while the car is in state DOOR.
REQ-010 SHALL have port arrive  output  1  one-cycle pulse on entry to DOOR.
REQ-011 SHALL have port pending  output  4  latched, unserved requests.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, MOVE and DOOR, and SHALL make all outputs registered.
REQ-013 SHALL latch requests as pending <= pending | call every cycle, so a call at edge t is visible on pending at t+1.
REQ-014 SHALL behave as follows in IDLE:
- if pending[cur_floor] is set, go to DOOR;
- else if pending holds requests in direction dir, go to MOVE keeping dir;
- else if pending holds requests in the opposite direction, go to MOVE with dir inverted;
- else stay in IDLE.
REQ-015 SHALL behave as follows in MOVE:
- the travel counter counts 0..TRAVEL_CYC-1;
- on the edge where the count equals TRAVEL_CYC-1, cur_floor steps by +1 (dir=1) or -1 (dir=0) and the counter returns to 0;
- moving from floor 0 to floor 2 therefore takes exactly 2*TRAVEL_CYC cycles in MOVE.
REQ-016 SHALL evaluate the new floor on that same stepping edge:
- if pending[new floor] is set, go to DOOR, clear that pending bit, and assert arrive for one cycle;
- else if requests remain beyond the new floor in dir, stay in MOVE;
- else go to IDLE.
REQ-017 SHALL, in DOOR, count DOOR_CYC cycles with door_open high, then go to IDLE.
REQ-018 SHALL, in DOOR, treat a call for cur_floor as follows: not latched, and restarts the door counter at 0.
REQ-019 SHALL clear a pending bit on arrival even when a call for the same floor arrives on the same edge, and SHALL not re-latch that call.
REQ-020 SHALL never decrement cur_floor below 0 or increment it above 3:
- at floor 3, dir is forced to 0 on the next MOVE entry;
- at floor 0, dir is forced to 1 on the next MOVE entry.
REQ-021 SHALL latch calls for floors other than cur_floor in every state, including DOOR and MOVE.

Reset
REQ-022 SHALL, when clr is high at a rising edge, set state=IDLE, cur_floor=0, dir=1, moving=0, door_open=0, arrive=0, pending=0, and both counters to 0.
REQ-023 SHALL give clr priority over all other activity, including mid-MOVE and mid-DOOR operation.
REQ-024 SHALL discard all pending requests on reset and SHALL ignore call on the reset edge.

Configuration
REQ-025 SHALL, when ELEVSCHED_DOOR_HOLD_EN is defined:
- add input door_hold (1 bit);
- freeze the door counter while door_hold is high in DOOR, keeping door_open high;
- have door_hold no effect in other states.
REQ-026 SHALL, when ELEVSCHED_DOOR_HOLD_EN is undefined, omit the door_hold port and leave DOOR timing fixed at DOOR_CYC (plus restarts per REQ-018).

Verification
REQ-027 SHALL pass this scenario: reset, then call=4'b0100 for one cycle -> pending=0100 next cycle; MOVE up; cur_floor=1 after 4 cycles and 2 after 8; arrive pulses; pending=0000; door_open high for 8 cycles; then IDLE.
REQ-028 SHALL pass this scenario: car at floor 0 in IDLE, call=4'b0001 -> DOOR next cycle, arrive pulses, cur_floor stays 0, moving never asserts.
REQ-029 SHALL pass this scenario: car moving up from floor 0 toward floor 3, call=4'b0010 arrives before the floor-1 step -> stops at floor 1, doors cycle, then resumes up to floor 3.
REQ-030 SHALL pass this scenario: car at floor 2 in DOOR with dir=1, calls for floors 0 and 3 -> serves floor 3 first (dir kept), then reverses to floor 0.
REQ-031 SHALL pass this scenario: clr asserted mid-MOVE with cur_floor=2 and pending=1001 -> next cycle cur_floor=0, pending=0000, moving=0, dir=1.
REQ-032 SHALL pass this scenario: in DOOR at floor 1, repeated call=4'b0010 at cycle 5 of the door interval -> door_open stays high 8 more cycles and pending[1] stays 0.

Source files
------------

// File: rtl/elevator_sched.sv
// elevator_sched: four-floor elevator car scheduler.
//
// Keeps latched floor requests and serves them in the current travel
// direction. It reverses direction only when nothing is left ahead of the
// car. The FSM has three states: IDLE, MOVE and DOOR. Every output comes
// straight from a register.
//
// Parameters:
//   TRAVEL_CYC  clock cycles to travel one floor (1..255)
//   DOOR_CYC    clock cycles the door stays open (1..255)
//
// Ports:
//   clk        in   rising-edge clock
//   clr        in   synchronous active-high reset
//   call[3:0]  in   floor request pulses (bit0 = ground floor)
//   door_hold  in   freezes the door timer while in DOOR
//                   (present only with ELEVSCHED_DOOR_HOLD_EN)
//   cur_floor  out  current floor 0..3
//   dir        out  travel direction (1 = up, 0 = down)
//   moving     out  car is in MOVE
//   door_open  out  car is in DOOR
//   arrive     out  one-cycle pulse on entry to DOOR
//   pending    out  latched, unserved requests
//
// Optional feature macro: ELEVSCHED_DOOR_HOLD_EN
module elevator_sched #(
   parameter int unsigned TRAVEL_CYC = 4,
   parameter int unsigned DOOR_CYC   = 8
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] call,
`ifdef ELEVSCHED_DOOR_HOLD_EN
   input  logic       door_hold,
`endif
   output logic [1:0] cur_floor,
   output logic       dir,
   output logic       moving,
   output logic       door_open,
   output logic       arrive,
   output logic [3:0] pending
);

   typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR} state_t;

   localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYC - 1);
   localparam logic [7:0] DOOR_LAST   = 8'(DOOR_CYC - 1);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_floor, w_floor_nxt;
   logic       r_dir, w_dir_nxt;
   logic       r_moving, r_door, r_arrive, w_arrive_nxt;
   logic [3:0] r_pending, w_pend_nxt;
   logic [7:0] r_tcnt, w_tcnt_nxt;
   logic [7:0] r_dcnt, w_dcnt_nxt;

   logic       w_hold;
   logic [1:0] w_nf;
   logic [3:0] w_above, w_below, w_above_nf, w_below_nf;
   logic       w_ahead, w_behind, w_ahead_nf;

`ifdef ELEVSCHED_DOOR_HOLD_EN
   assign w_hold = door_hold;
`else
   assign w_hold = 1'b0;
`endif

   // Floor the car reaches on the current step. The value is only used in
   // MOVE, where the direction guarantees it stays within 0..3.
   assign w_nf = r_dir ? r_floor + 2'd1 : r_floor - 2'd1;

   always_comb begin
      w_above    = '0;
      w_below    = '0;
      w_above_nf = '0;
      w_below_nf = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         w_above[i]    = 2'(i) > r_floor;
         w_below[i]    = 2'(i) < r_floor;
         w_above_nf[i] = 2'(i) > w_nf;
         w_below_nf[i] = 2'(i) < w_nf;
      end
   end

   assign w_ahead    = r_dir ? |(r_pending & w_above) : |(r_pending & w_below);
   assign w_behind   = r_dir ? |(r_pending & w_below) : |(r_pending & w_above);
   assign w_ahead_nf = r_dir ? |(r_pending & w_above_nf) : |(r_pending & w_below_nf);

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state   <= ST_IDLE;
         r_floor   <= '0;
         r_dir     <= 1'b1;
         r_moving  <= 1'b0;
         r_door    <= 1'b0;
         r_arrive  <= 1'b0;
         r_pending <= '0;
         r_tcnt    <= '0;
         r_dcnt    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_floor   <= w_floor_nxt;
         r_dir     <= w_dir_nxt;
         r_moving  <= (w_state_nxt == ST_MOVE);
         r_door    <= (w_state_nxt == ST_DOOR);
         r_arrive  <= w_arrive_nxt;
         r_pending <= w_pend_nxt;
         r_tcnt    <= w_tcnt_nxt;
         r_dcnt    <= w_dcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_floor_nxt  = r_floor;
      w_dir_nxt    = r_dir;
      w_arrive_nxt = 1'b0;
      w_pend_nxt   = r_pending | call;
      w_tcnt_nxt   = r_tcnt;
      w_dcnt_nxt   = r_dcnt;
      case (r_state)
         ST_IDLE: begin
            if (r_pending[r_floor]) begin
               // The bit is served now, so a same-edge call for it is dropped.
               w_state_nxt         = ST_DOOR;
               w_dcnt_nxt          = '0;
               w_arrive_nxt        = 1'b1;
               w_pend_nxt[r_floor] = 1'b0;
            end else if (w_ahead) begin
               w_state_nxt = ST_MOVE;
               w_tcnt_nxt  = '0;
            end else if (w_behind) begin
               // At floor 0 or floor 3 only the opposite side can hold
               // requests, so this branch also sets the forced direction.
               w_state_nxt = ST_MOVE;
               w_dir_nxt   = ~r_dir;
               w_tcnt_nxt  = '0;
            end
         end
         ST_MOVE: begin
            if (r_tcnt == TRAVEL_LAST) begin
               w_tcnt_nxt  = '0;
               w_floor_nxt = w_nf;
               if (r_pending[w_nf]) begin
                  w_state_nxt      = ST_DOOR;
                  w_dcnt_nxt       = '0;
                  w_arrive_nxt     = 1'b1;
                  w_pend_nxt[w_nf] = 1'b0;
               end else if (!w_ahead_nf) begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_tcnt_nxt = r_tcnt + 8'd1;
            end
         end
         ST_DOOR: begin
            // A call for the open floor is never latched; it only restarts the timer.
            w_pend_nxt[r_floor] = 1'b0;
            if (call[r_floor]) begin
               w_dcnt_nxt = '0;
            end else if (!w_hold) begin
               if (r_dcnt == DOOR_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_dcnt_nxt  = '0;
               end else begin
                  w_dcnt_nxt = r_dcnt + 8'd1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign cur_floor = r_floor;
   assign dir       = r_dir;
   assign moving    = r_moving;
   assign door_open = r_door;
   assign arrive    = r_arrive;
   assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_sched.sv
// Testbench for elevator_sched.
//
// A behavioural model of the car tracks the expected outputs. It counts the
// remaining travel or door time down, and keeps the requests as a plain bit
// array. All DUT outputs are compared with the model after every clock edge.
// Directed scenarios run first, then randomized calls and resets.
module tb_elevator_sched;

   localparam int TRV = 4;
   localparam int DR  = 8;

   logic       clk;
   logic       clr;
   logic [3:0] call;
   logic       door_hold;
   logic [1:0] cur_floor;
   logic       dir, moving, door_open, arrive;
   logic [3:0] pending;

   int errors = 0;
   int checks = 0;

   elevator_sched #(.TRAVEL_CYC(TRV), .DOOR_CYC(DR)) dut (
      .clk       (clk),
      .clr       (clr),
      .call      (call),
`ifdef ELEVSCHED_DOOR_HOLD_EN
      .door_hold (door_hold),
`endif
      .cur_floor (cur_floor),
      .dir       (dir),
      .moving    (moving),
      .door_open (door_open),
      .arrive    (arrive),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: mode 0 = idle, 1 = travelling, 2 = door open.
   int m_mode;
   int m_floor;
   bit m_up;
   bit m_req [4];
   int m_left;
   bit m_arr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit want(input bit up, input int fl);
      bit r = 0;
      for (int f = 0; f < 4; f++)
         if (m_req[f] && (up ? (f > fl) : (f < fl))) r = 1;
      return r;
   endfunction

   function automatic logic [3:0] req_bits();
      logic [3:0] v = '0;
      for (int f = 0; f < 4; f++) v[f] = m_req[f];
      return v;
   endfunction

   task automatic model_step(input bit c_clr, input logic [3:0] c_call, input bit c_hold);
      bit nreq [4];
      if (c_clr) begin
         m_mode = 0; m_floor = 0; m_up = 1; m_left = 0; m_arr = 0;
         for (int f = 0; f < 4; f++) m_req[f] = 0;
         return;
      end
      m_arr = 0;
      for (int f = 0; f < 4; f++) nreq[f] = m_req[f] | c_call[f];
      case (m_mode)
         0: begin
            if (m_req[m_floor]) begin
               m_mode = 2; m_left = DR; m_arr = 1; nreq[m_floor] = 0;
            end else if (want(m_up, m_floor)) begin
               m_mode = 1; m_left = TRV;
            end else if (want(!m_up, m_floor)) begin
               m_up = !m_up; m_mode = 1; m_left = TRV;
            end
         end
         1: begin
            m_left--;
            if (m_left == 0) begin
               m_floor = m_up ? m_floor + 1 : m_floor - 1;
               if (m_req[m_floor]) begin
                  m_mode = 2; m_left = DR; m_arr = 1; nreq[m_floor] = 0;
               end else if (want(m_up, m_floor)) begin
                  m_left = TRV;
               end else begin
                  m_mode = 0;
               end
            end
         end
         default: begin
            nreq[m_floor] = 0;
            if (c_call[m_floor]) m_left = DR;
            else if (!c_hold) begin
               m_left--;
               if (m_left == 0) m_mode = 0;
            end
         end
      endcase
      for (int f = 0; f < 4; f++) m_req[f] = nreq[f];
   endtask

   task automatic compare_all();
      chk("cur_floor", 32'(cur_floor), 32'(m_floor));
      chk("dir",       32'(dir),       32'(m_up));
      chk("moving",    32'(moving),    32'(m_mode == 1));
      chk("door_open", 32'(door_open), 32'(m_mode == 2));
      chk("arrive",    32'(arrive),    32'(m_arr));
      chk("pending",   32'(pending),   32'(req_bits()));
   endtask

   task automatic cycle(input bit c_clr, input logic [3:0] c_call, input bit c_hold);
      @(negedge clk);
      clr       = c_clr;
      call      = c_call;
      door_hold = c_hold;
`ifdef ELEVSCHED_DOOR_HOLD_EN
      model_step(c_clr, c_call, c_hold);
`else
      model_step(c_clr, c_call, 1'b0);
`endif
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 4'b0000, 1'b0);
   endtask

   initial begin
      clr = 1'b1; call = '0; door_hold = 1'b0;

      // Reset, then ride from floor 0 to floor 2.
      cycle(1'b1, 4'b1111, 1'b0);
      chk("rst_floor", 32'(cur_floor), 32'd0);
      chk("rst_pend",  32'(pending),   32'd0);
      chk("rst_dir",   32'(dir),       32'd1);
      cycle(1'b0, 4'b0100, 1'b0);
      chk("s1_pend", 32'(pending), 32'b0100);
      cycle(1'b0, 4'b0000, 1'b0);
      chk("s1_moving", 32'(moving), 32'd1);
      idle_cycles(4);
      chk("s1_floor1", 32'(cur_floor), 32'd1);
      idle_cycles(4);
      chk("s1_floor2", 32'(cur_floor), 32'd2);
      chk("s1_arrive", 32'(arrive),    32'd1);
      chk("s1_pend0",  32'(pending),   32'd0);
      for (int k = 0; k < DR - 1; k++) begin
         cycle(1'b0, 4'b0000, 1'b0);
         chk("s1_door_hi", 32'(door_open), 32'd1);
      end
      cycle(1'b0, 4'b0000, 1'b0);
      chk("s1_door_lo", 32'(door_open), 32'd0);
      chk("s1_idle",    32'(moving),    32'd0);

      // Call at the current floor while idle: door opens without moving.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0001, 1'b0);
      cycle(1'b0, 4'b0000, 1'b0);
      chk("s2_door",   32'(door_open), 32'd1);
      chk("s2_arrive", 32'(arrive),    32'd1);
      chk("s2_floor",  32'(cur_floor), 32'd0);
      idle_cycles(DR);

      // Intermediate stop on the way up to floor 3.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b1000, 1'b0);
      cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0010, 1'b0);
      idle_cycles(3);
      chk("s3_stop1", 32'(cur_floor), 32'd1);
      chk("s3_door1", 32'(door_open), 32'd1);
      idle_cycles(DR + 1 + 2 * TRV);
      chk("s3_floor3", 32'(cur_floor), 32'd3);
      idle_cycles(DR + 2);

      // Door at floor 2 going up, calls at 0 and 3: up first, then down.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0100, 1'b0);
      idle_cycles(1 + 2 * TRV);
      cycle(1'b0, 4'b1001, 1'b0);
      idle_cycles(DR + TRV);
      chk("s4_up3",  32'(cur_floor), 32'd3);
      idle_cycles(DR + 1 + 3 * TRV);
      chk("s4_down", 32'(cur_floor), 32'd0);
      chk("s4_dir",  32'(dir),       32'd0);
      idle_cycles(DR + 2);

      // Reset during MOVE at floor 2 with 1001 pending.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b1000, 1'b0);
      idle_cycles(1 + 2 * TRV);
      cycle(1'b0, 4'b0001, 1'b0);
      chk("s5_pre_pend",  32'(pending),   32'b1001);
      chk("s5_pre_floor", 32'(cur_floor), 32'd2);
      cycle(1'b1, 4'b0100, 1'b0);
      chk("s5_floor",  32'(cur_floor), 32'd0);
      chk("s5_pend",   32'(pending),   32'd0);
      chk("s5_moving", 32'(moving),    32'd0);
      chk("s5_dir",    32'(dir),       32'd1);

      // Door restart by a repeated call at floor 1.
      cycle(1'b0, 4'b0010, 1'b0);
      idle_cycles(1 + TRV);
      chk("s6_arrive", 32'(arrive), 32'd1);
      idle_cycles(4);
      cycle(1'b0, 4'b0010, 1'b0);
      chk("s6_pend1", 32'(pending[1]), 32'd0);
      for (int k = 0; k < DR - 1; k++) begin
         cycle(1'b0, 4'b0000, 1'b0);
         chk("s6_door_hi", 32'(door_open), 32'd1);
      end
      cycle(1'b0, 4'b0000, 1'b0);
      chk("s6_door_lo", 32'(door_open), 32'd0);

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 4000; k++) begin
         logic [3:0] c;
         bit r, h;
         c = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         r = ($urandom_range(0, 299) == 0);
         h = ($urandom_range(0, 3) == 0);
         cycle(r, c, h);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
